alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Operand/write-back sequencer that sits around the N-bit ALU. It owns a small register file and the carry/zero flags. It accepts one operation request over a valid/ready handshake, drives the ALU operand, mode and carry-in inputs from registered state, then captures the ALU result and carry-out. It writes the result back to the register file, updates the flags and pulses done. It is the ALU's direct upstream feeder and downstream consumer.

Parameters:
N, 8, datapath width (matches ALU N)
NREG, 4, number of registers (power of two)
AW, 2, register address width, log2(NREG)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept (high only in IDLE)
req_op  in  3  ALU mode code (`ALU_ADD/`ALU_SUB/`ALU_INC/`ALU_DEC)
req_use_c  in  1  ADD only: use flag C as carry-in
req_dst  in  AW  destination register
req_srca  in  AW  operand A register
req_srcb  in  AW  operand B register (ignored for INC/DEC)
ld_en  in  1  direct register load strobe
ld_addr  in  AW  load address
ld_data  in  N  load data
rd_addr  in  AW  debug read address
rd_data  out  N  combinational read of reg[rd_addr]
alu_mode  out  3  to ALU mode
alu_cin  out  1  to ALU cin
alu_a  out  N  to ALU in_a
alu_b  out  N  to ALU in_b
alu_out  in  N  from ALU out
alu_cout  in  1  from ALU cout
flag_c  out  1  carry/borrow flag
flag_z  out  1  zero flag (result == 0)
done  out  1  one-cycle pulse: operation retired
done_err  out  1  qualifies done: illegal op, nothing written

Behaviour:
- Reset (asynchronous, rst_n low):
  - All registers = 0; flag_c = flag_z = 0.
  - State = IDLE; done = done_err = 0.
  - Latched op/dst/src = 0, so alu_mode = 0 and alu_a = alu_b = 0 (reg0), alu_cin = 0.
- FSM IDLE -> EXEC -> WB -> IDLE.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid, the request is accepted: latch op, use_c, dst, srca, srcb. Next state is EXEC.
- EXEC:
  - alu_a = reg[srca_q]; alu_b = reg[srcb_q]; alu_mode = op_q.
  - alu_cin = use_c_q & flag_c for ADD, else 0.
  - At the edge, capture alu_out into res_q and alu_cout into cry_q. Next state is WB.
- WB:
  - At the edge, write reg[dst_q] = res_q, flag_c = cry_q, flag_z = (res_q == 0).
  - done = 1 for the following cycle. Next state is IDLE.
- Latency: acceptance at edge T0 → register and flags visible after edge T2 → done high in cycle T2..T3. Throughput is 1 op per 3 cycles. req_ready is high again in the done cycle, so back-to-back requests are allowed.
- Flag semantics (N+1-bit ALU arithmetic):
  - ADD: C = carry out.
  - SUB: C = 1 iff a < b (borrow).
  - INC: C = 1 iff a = all-ones.
  - DEC: C = 1 iff a = 0.
  - Z is computed from the result inside this block. The ALU eq_zero output (in_a == 0) is not used.
- Illegal op (any code other than the four):
  - Accepted and sequenced normally.
  - In WB: no register write, flags unchanged; done and done_err both pulse.
- ld_en:
  - Honoured only in IDLE: reg[ld_addr] = ld_data at the edge.
  - Ignored in EXEC/WB; no effect, no error.
  - ld_en together with request acceptance: the load completes at the same edge, and EXEC sees the loaded value.
- Operand aliasing: srca == srcb == dst is legal. Operands are read in EXEC, before the write-back.
- Reset mid-operation (EXEC or WB): the operation is abandoned, there is no write, and all state takes its reset values.
- req inputs are don't-care when req_ready = 0; requests are never queued.

Decomposition:
- Shared constants: ALU mode codes stay in `rtl/parameters.v`. Add the FSM state encodings (`SEQ_IDLE`, `SEQ_EXEC`, `SEQ_WB`) there.
- One natural sub-module: `regfile` (NREG x N, one synchronous write port, one combinational read port per operand plus debug). Its write mux arbitrates ld_en versus WB; these are mutually exclusive by state.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset: after rst_n release, rd_data = 0 for all addresses, flag_c = flag_z = 0, req_ready = 1, done = 0.
- Load r0 = 0xF0, r1 = 0x20; ADD r2 = r0 + r1 → r2 = 0x10, C = 1, Z = 0. done occurs exactly 2 edges after acceptance; req_ready is low for 2 cycles.
- Carry chain:
  - r0 = 0xFF, r1 = 0x01: ADD r2 → 0x00, C = 1, Z = 1.
  - Then ADD use_c r3 = r2 + r2 → 0x01, C = 0, Z = 0.
  - Then ADD with use_c = 0 ignores C.
- SUB 0x05 - 0x07 → 0xFE, C = 1.
- DEC 0x00 → 0xFF, C = 1.
- INC 0xFF → 0x00, C = 1, Z = 1.
- SUB r0 - r0 with r0 = 0x33, dst = r0 → 0x00, Z = 1, C = 0.
- Hold req_valid through busy → exactly one acceptance per 3 cycles.
- ld_en in EXEC → register unchanged.
- ld_en plus acceptance in IDLE → the op uses the loaded value.
- Illegal op 3'b111 → done = done_err = 1, registers and flags unchanged.
- rst_n pulsed low during WB → no write, all outputs at reset values.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU mode codes, sequencer state encoding and op decode shared by the alu_seq slice.
package alu_seq_pkg;
  localparam int OPW = 3;
  localparam logic [OPW-1:0] ALU_ADD = 3'd0;
  localparam logic [OPW-1:0] ALU_SUB = 3'd1;
  localparam logic [OPW-1:0] ALU_INC = 3'd2;
  localparam logic [OPW-1:0] ALU_DEC = 3'd3;
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_EXEC = 2'd1,
    SEQ_WB   = 2'd2
  } seq_state_t;
  function automatic logic op_legal(input logic [OPW-1:0] op);
    return op inside {ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC};
  endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation request handshake between a requester (master) and the sequencer (slave).
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int AW = 2
);
  logic           req_valid;
  logic           req_ready;
  logic [OPW-1:0] req_op;
  logic           req_use_c;
  logic [AW-1:0]  req_dst;
  logic [AW-1:0]  req_srca;
  logic [AW-1:0]  req_srcb;
  modport master(output req_valid, req_op, req_use_c, req_dst, req_srca, req_srcb, input req_ready);
  modport slave(input req_valid, req_op, req_use_c, req_dst, req_srca, req_srcb, output req_ready);
endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x N register file, one write port shared by direct load and write-back,
// combinational reads for both operands and a debug port.
module alu_seq_regfile #(
  parameter int N    = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  wb_data,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  ra_data,
  output logic [N-1:0]  rb_data,
  output logic [N-1:0]  rd_data
);
  logic [N-1:0]  mem_q [NREG];
  logic          we;
  logic [AW-1:0] wa;
  logic [N-1:0]  wd;
  // ld_en and wb_en never coincide: the parent gates them by state
  assign we = ld_en | wb_en;
  assign wa = wb_en ? wb_addr : ld_addr;
  assign wd = wb_en ? wb_data : ld_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end
  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];
  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/alu_seq.sv
// alu_seq: operand/write-back sequencer around an external ALU; owns the register file and C/Z flags.
// Each request runs IDLE -> EXEC -> WB and retires with a one-cycle done pulse.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_if.slave       req,
  input  logic           ld_en,
  input  logic [AW-1:0]  ld_addr,
  input  logic [N-1:0]   ld_data,
  input  logic [AW-1:0]  rd_addr,
  output logic [N-1:0]   rd_data,
  output logic [OPW-1:0] alu_mode,
  output logic           alu_cin,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  input  logic [N-1:0]   alu_out,
  input  logic           alu_cout,
  output logic           flag_c,
  output logic           flag_z,
  output logic           done,
  output logic           done_err
);
  seq_state_t     state_q, state_d;
  logic [OPW-1:0] op_q;
  logic           use_c_q;
  logic [AW-1:0]  dst_q, srca_q, srcb_q;
  logic [N-1:0]   res_q;
  logic           cry_q, fc_q, fz_q, done_q, err_q;
  logic           idle, accept, legal, wb_en;
  assign idle   = state_q == SEQ_IDLE;
  assign accept = idle && req.req_valid;
  assign legal  = op_legal(op_q);
  assign wb_en  = state_q == SEQ_WB && legal;
  always_comb begin
    state_d = state_q;
    req.req_ready = idle;
    case (state_q)
      SEQ_IDLE: state_d = req.req_valid ? SEQ_EXEC : SEQ_IDLE;
      SEQ_EXEC: state_d = SEQ_WB;
      default:  state_d = SEQ_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      op_q    <= '0;
      use_c_q <= 1'b0;
      dst_q   <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      res_q   <= '0;
      cry_q   <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == SEQ_WB;
      err_q   <= state_q == SEQ_WB && !legal;
      if (accept) begin
        op_q    <= req.req_op;
        use_c_q <= req.req_use_c;
        dst_q   <= req.req_dst;
        srca_q  <= req.req_srca;
        srcb_q  <= req.req_srcb;
      end
      if (state_q == SEQ_EXEC) begin
        res_q <= alu_out;
        cry_q <= alu_cout;
      end
      // illegal ops retire without touching the flags
      if (wb_en) begin
        fc_q <= cry_q;
        fz_q <= res_q == '0;
      end
    end
  end
  alu_seq_regfile #(.N(N), .NREG(NREG), .AW(AW)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_en   (ld_en && idle),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wb_en   (wb_en),
    .wb_addr (dst_q),
    .wb_data (res_q),
    .ra_addr (srca_q),
    .rb_addr (srcb_q),
    .rd_addr (rd_addr),
    .ra_data (alu_a),
    .rb_data (alu_b),
    .rd_data (rd_data)
  );
  assign alu_mode = op_q;
  assign alu_cin  = state_q == SEQ_EXEC && op_q == ALU_ADD && use_c_q && fc_q;
  assign flag_c   = fc_q;
  assign flag_z   = fz_q;
  assign done     = done_q;
  assign done_err = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand sequences for alu_seq, with a behavioural N-bit ALU attached.
module tb_alu_seq;
  import alu_seq_pkg::*;
  localparam int N = 8, NREG = 4, AW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_seq_if #(.AW(AW)) bus();
  logic           ld_en;
  logic [AW-1:0]  ld_addr, rd_addr;
  logic [N-1:0]   ld_data, rd_data, alu_a, alu_b, alu_out;
  logic [OPW-1:0] alu_mode;
  logic           alu_cin, alu_cout, flag_c, flag_z, done, done_err;
  logic [N:0]     alu_r;
  alu_seq #(.N(N), .NREG(NREG), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .alu_mode (alu_mode),
    .alu_cin  (alu_cin),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .alu_cout (alu_cout),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .done     (done),
    .done_err (done_err)
  );
  // external ALU: N+1-bit arithmetic, bit N is cout; SUB takes cin as borrow-in
  always_comb begin
    case (alu_mode)
      ALU_ADD: alu_r = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
      ALU_SUB: alu_r = {1'b0, alu_a} - {1'b0, alu_b} - {{N{1'b0}}, alu_cin};
      ALU_INC: alu_r = {1'b0, alu_a} + 9'd1;
      ALU_DEC: alu_r = {1'b0, alu_a} - 9'd1;
      default: alu_r = {1'b1, ~alu_a};
    endcase
  end
  assign {alu_cout, alu_out} = alu_r;
  typedef struct {
    logic           do_ld;
    logic [AW-1:0]  la;
    logic [N-1:0]   va;
    logic [AW-1:0]  lb;
    logic [N-1:0]   vb;
    logic [OPW-1:0] op;
    logic           uc;
    logic [AW-1:0]  d, sa, sb;
    logic [N-1:0]   res;
    logic           c, z;
  } vec_t;
  vec_t tbl [11];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic rdreg(input logic [AW-1:0] a, output logic [N-1:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask
  task automatic load(input logic [AW-1:0] a, input logic [N-1:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask
  task automatic run_op(input string name, input logic [OPW-1:0] op, input logic uc,
                        input logic [AW-1:0] d, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                        input logic exp_err);
    chk({name, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_use_c = uc;
    bus.req_dst = d;
    bus.req_srca = sa;
    bus.req_srcb = sb;
    @(negedge clk);
    bus.req_valid = 1'b0;
    ld_en = 1'b0;
    chk({name, " exec ready/done"}, 32'({bus.req_ready, done}), 32'd0);
    @(negedge clk);
    chk({name, " wb ready/done"}, 32'({bus.req_ready, done}), 32'd0);
    @(negedge clk);
    chk({name, " ready/done/err"}, 32'({bus.req_ready, done, done_err}), 32'({2'b11, exp_err}));
  endtask
  function automatic vec_t mk(input logic dl, input logic [AW-1:0] la, input logic [N-1:0] va,
                              input logic [AW-1:0] lb, input logic [N-1:0] vb, input logic [OPW-1:0] op,
                              input logic uc, input logic [AW-1:0] d, input logic [AW-1:0] sa,
                              input logic [AW-1:0] sb, input logic [N-1:0] res, input logic c, input logic z);
    vec_t v;
    v.do_ld = dl; v.la = la; v.va = va; v.lb = lb; v.vb = vb; v.op = op; v.uc = uc;
    v.d = d; v.sa = sa; v.sb = sb; v.res = res; v.c = c; v.z = z;
    return v;
  endfunction
  initial begin
    logic [N-1:0] v;
    int cnt;
    tbl[0]  = mk(1'b1, 2'd0, 8'hF0, 2'd1, 8'h20, ALU_ADD, 1'b0, 2'd2, 2'd0, 2'd1, 8'h10, 1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 2'd0, 8'hFF, 2'd1, 8'h01, ALU_ADD, 1'b0, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1, 1'b1);
    tbl[2]  = mk(1'b0, 2'd0, 8'h00, 2'd0, 8'h00, ALU_ADD, 1'b0, 2'd3, 2'd1, 2'd1, 8'h02, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 2'd0, 8'hFF, 2'd1, 8'h01, ALU_ADD, 1'b0, 2'd2, 2'd0, 2'd1, 8'h00, 1'b1, 1'b1);
    tbl[4]  = mk(1'b0, 2'd0, 8'h00, 2'd0, 8'h00, ALU_ADD, 1'b1, 2'd3, 2'd2, 2'd2, 8'h01, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 2'd0, 8'h05, 2'd1, 8'h07, ALU_SUB, 1'b0, 2'd2, 2'd0, 2'd1, 8'hFE, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 2'd0, 8'h00, 2'd1, 8'h99, ALU_DEC, 1'b0, 2'd2, 2'd0, 2'd1, 8'hFF, 1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 2'd0, 8'hFF, 2'd1, 8'h00, ALU_INC, 1'b0, 2'd3, 2'd0, 2'd1, 8'h00, 1'b1, 1'b1);
    tbl[8]  = mk(1'b1, 2'd1, 8'h10, 2'd2, 8'h03, ALU_SUB, 1'b1, 2'd0, 2'd1, 2'd2, 8'h0D, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 2'd0, 8'h33, 2'd1, 8'h55, ALU_SUB, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b1);
    tbl[10] = mk(1'b1, 2'd1, 8'h80, 2'd2, 8'h7F, ALU_ADD, 1'b1, 2'd3, 2'd1, 2'd2, 8'hFF, 1'b0, 1'b0);
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_use_c = 1'b0;
    bus.req_dst = '0; bus.req_srca = '0; bus.req_srcb = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NREG; i++) begin
      rdreg(AW'(i), v);
      chk($sformatf("reset r%0d", i), 32'(v), 32'd0);
    end
    chk("reset flags/ready/done/err", 32'({flag_c, flag_z, bus.req_ready, done, done_err}), 32'b00100);
    chk("reset alu a/b/mode/cin", 32'({alu_a, alu_b, alu_mode, alu_cin}), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].do_ld) begin
        load(tbl[i].la, tbl[i].va);
        load(tbl[i].lb, tbl[i].vb);
      end
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].uc, tbl[i].d, tbl[i].sa, tbl[i].sb, 1'b0);
      rdreg(tbl[i].d, v);
      chk($sformatf("vec%0d result", i), 32'(v), 32'(tbl[i].res));
      chk($sformatf("vec%0d C", i), 32'(flag_c), 32'(tbl[i].c));
      chk($sformatf("vec%0d Z", i), 32'(flag_z), 32'(tbl[i].z));
    end
    @(negedge clk);
    // req_valid held high: one acceptance every third cycle
    load(2'd1, 8'h11);
    bus.req_valid = 1'b1; bus.req_op = ALU_ADD; bus.req_use_c = 1'b0;
    bus.req_dst = 2'd3; bus.req_srca = 2'd1; bus.req_srcb = 2'd1;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    bus.req_valid = 1'b0;
    chk("hold done count", 32'(cnt), 32'd3);
    rdreg(2'd3, v);
    chk("hold result", 32'(v), 32'h22);
    @(negedge clk);
    chk("hold no extra accept", 32'(bus.req_ready), 32'd1);
    // ld_en during EXEC and WB must be ignored
    load(2'd0, 8'h5A);
    load(2'd1, 8'h05);
    bus.req_valid = 1'b1; bus.req_op = ALU_ADD; bus.req_use_c = 1'b0;
    bus.req_dst = 2'd2; bus.req_srca = 2'd1; bus.req_srcb = 2'd1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    ld_en = 1'b0;
    chk("busy-load done", 32'(done), 32'd1);
    rdreg(2'd0, v);
    chk("busy-load r0 kept", 32'(v), 32'h5A);
    rdreg(2'd2, v);
    chk("busy-load result", 32'(v), 32'h0A);
    @(negedge clk);
    // load at the acceptance edge feeds EXEC
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'h40;
    run_op("ld+accept", ALU_INC, 1'b0, 2'd2, 2'd1, 2'd1, 1'b0);
    rdreg(2'd2, v);
    chk("ld+accept result", 32'(v), 32'h41);
    rdreg(2'd1, v);
    chk("ld+accept r1", 32'(v), 32'h40);
    chk("ld+accept C/Z", 32'({flag_c, flag_z}), 32'd0);
    @(negedge clk);
    // illegal op: set C=Z=1 first, then confirm nothing changes
    load(2'd0, 8'hFF);
    run_op("inc-setup", ALU_INC, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0);
    run_op("illegal", 3'b111, 1'b0, 2'd2, 2'd0, 2'd1, 1'b1);
    rdreg(2'd2, v);
    chk("illegal r2 kept", 32'(v), 32'h41);
    rdreg(2'd3, v);
    chk("illegal r3 kept", 32'(v), 32'h00);
    chk("illegal C/Z kept", 32'({flag_c, flag_z}), 32'b11);
    @(negedge clk);
    // reset asserted in WB abandons the write
    load(2'd0, 8'h01);
    load(2'd1, 8'h02);
    bus.req_valid = 1'b1; bus.req_op = ALU_ADD; bus.req_use_c = 1'b1;
    bus.req_dst = 2'd2; bus.req_srca = 2'd0; bus.req_srcb = 2'd1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wb-reset flags/ready/done/err", 32'({flag_c, flag_z, bus.req_ready, done, done_err}), 32'b00100);
    chk("wb-reset alu a/b/mode/cin", 32'({alu_a, alu_b, alu_mode, alu_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("wb-reset no done", 32'(cnt), 32'd0);
    for (int i = 0; i < NREG; i++) begin
      rdreg(AW'(i), v);
      chk($sformatf("wb-reset r%0d", i), 32'(v), 32'd0);
    end
    chk("wb-reset flags after", 32'({flag_c, flag_z}), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
